// File: rtl/instr_encoder_tx_if.sv
// Command, instruction and status signals between the host controller,
// the instruction encoder and the coprocessor.
interface instr_encoder_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [3:0]                   cmd_opcode;
    logic [5:0]                   cmd_location;
    logic [1:0]                   cmd_id;
    logic [15:0]                  cmd_data;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [31:0]                  instruction;
    logic                         cop_done;
    logic                         busy;
    logic                         timeout;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    // Encoder side: accepts commands, issues instructions.
    modport master (
        input  cmd_valid, cmd_opcode, cmd_location, cmd_id, cmd_data,
        input  instr_ready, cop_done,
        output cmd_ready, instr_valid, instruction, busy, timeout, fifo_count
    );

    // Environment side: host controller plus coprocessor.
    modport slave (
        output cmd_valid, cmd_opcode, cmd_location, cmd_id, cmd_data,
        output instr_ready, cop_done,
        input  cmd_ready, instr_valid, instruction, busy, timeout, fifo_count
    );
endinterface

// File: rtl/instr_encoder_tx.sv
// Packs field-level commands into 32-bit instruction words, buffers them and issues
// one at a time, waiting for cop_done. Build option INSTR_PARITY_EN puts odd parity in bit 31.
//
// state     | meaning
// IDLE      | nothing in flight; move to ISSUE when the FIFO holds a word
// ISSUE     | FIFO head presented on instr_valid until instr_ready
// WAIT_DONE | word accepted; waiting for cop_done or timer expiry
module instr_encoder_tx #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    instr_encoder_tx_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [PW:0]   DEPTH_C    = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          timeout_q;
    logic          timeout_nxt;
    logic [31:0]   pack_word;
    logic          push;
    logic          pop;
    logic          empty;

    always_comb begin
        pack_word       = '0;
        pack_word[3:0]  = bus.cmd_opcode;
        if (bus.cmd_opcode[3]) begin
            pack_word[11:4]  = bus.cmd_data[15:8];
            pack_word[19:12] = bus.cmd_data[7:0];
        end else begin
            pack_word[9:4]   = bus.cmd_location;
            pack_word[11:10] = bus.cmd_id;
            pack_word[19:12] = bus.cmd_data[15:8];
            pack_word[27:20] = bus.cmd_data[7:0];
        end
`ifdef INSTR_PARITY_EN
        pack_word[31] = ~^pack_word[30:0];
`else
        pack_word[31] = 1'b0;
`endif
    end

    assign empty = (count == '0);
    assign push  = bus.cmd_valid && bus.cmd_ready;
    // ISSUE is only entered with a non-empty FIFO, so a pop never underflows.
    assign pop   = (state == ISSUE) && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pack_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Timer counts down from DONE_TIMEOUT-1; expiry is the wait cycle that finds it at zero.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    state_nxt = WAIT_DONE;
                    timer_nxt = TIMER_LOAD;
                end
            end
            WAIT_DONE: begin
                if (bus.cop_done) begin
                    state_nxt = IDLE;
                end else if (timer == '0) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = (count < DEPTH_C);
    assign bus.instr_valid = (state == ISSUE);
    assign bus.instruction = (state == ISSUE) ? mem[rd_ptr] : '0;
    assign bus.busy        = (state != IDLE) || !empty;
    assign bus.timeout     = timeout_q;
    assign bus.fifo_count  = count;
endmodule

// File: tb/tb_instr_encoder_tx.sv
// Directed bench for instr_encoder_tx: packing, latency, back-pressure, timeout and async reset.
module tb_instr_encoder_tx;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    instr_encoder_tx_if #(.FIFO_DEPTH(4)) bus ();

    instr_encoder_tx #(
        .FIFO_DEPTH   (4),
        .DONE_TIMEOUT (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fix(input logic [31:0] w);
`ifdef INSTR_PARITY_EN
        return {~^w[30:0], w[30:0]};
`else
        return w;
`endif
    endfunction

    task automatic push_cmd(input logic [3:0] op, input logic [5:0] loc,
                            input logic [1:0] id, input logic [15:0] data);
        bus.cmd_opcode   = op;
        bus.cmd_location = loc;
        bus.cmd_id       = id;
        bus.cmd_data     = data;
        bus.cmd_valid    = 1'b1;
        step();
        bus.cmd_valid    = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, bus.instr_valid, 1'b1);
    endtask

    task automatic pulse_done();
        bus.cop_done = 1'b1;
        step();
        bus.cop_done = 1'b0;
    endtask

    logic [31:0] exp_q [4];
    int          k;
    int          pulses;
    int          seen_valid;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst              = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_opcode   = '0;
        bus.cmd_location = '0;
        bus.cmd_id       = '0;
        bus.cmd_data     = '0;
        bus.instr_ready  = 1'b0;
        bus.cop_done     = 1'b0;

        exp_q[0] = fix(32'h0111_1011);
        exp_q[1] = fix(32'h000E_FBEA);
        exp_q[2] = fix(32'h0000_0FF3);
        exp_q[3] = fix(32'h0018_0407);

        step();
        step();
        check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check_eq("rst_instr_valid", bus.instr_valid, 1'b0);
        check_eq("rst_instruction", bus.instruction, 32'h0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_timeout", bus.timeout, 1'b0);
        check_eq("rst_fifo_count", bus.fifo_count, 3'd0);
        rst = 1'b0;
        step();

        // Single command, coprocessor always ready
        bus.instr_ready = 1'b1;
        push_cmd(4'h2, 6'h15, 2'b10, 16'hABCD);
        check_eq("s1_count_after_write", bus.fifo_count, 3'd1);
        check_eq("s1_valid_early", bus.instr_valid, 1'b0);
        check_eq("s1_busy", bus.busy, 1'b1);
        step();
        check_eq("s1_valid", bus.instr_valid, 1'b1);
        check_eq("s1_word", bus.instruction, fix(32'h0CDA_B952));
`ifdef INSTR_PARITY_EN
        check_eq("s1_parity_odd", 32'($countones(bus.instruction) % 2), 32'd1);
`else
        check_eq("s1_bit31", bus.instruction[31], 1'b0);
`endif
        step();
        check_eq("s1_popped", bus.fifo_count, 3'd0);
        check_eq("s1_valid_after_hs", bus.instr_valid, 1'b0);
        step();
        step();
        check_eq("s1_busy_waiting", bus.busy, 1'b1);
        pulse_done();
        check_eq("s1_busy_after_done", bus.busy, 1'b0);
        bus.instr_ready = 1'b0;

        // Opcode[3] layout ignores location and id
        push_cmd(4'h9, 6'h3F, 2'b11, 16'h1234);
        wait_valid("s2_valid");
        check_eq("s2_word", bus.instruction, fix(32'h0003_4129));
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        pulse_done();
        check_eq("s2_idle", bus.busy, 1'b0);

        // Fill the FIFO against back-pressure; the fifth command must be refused
        push_cmd(4'h1, 6'h01, 2'b00, 16'h1111);
        push_cmd(4'hA, 6'h2A, 2'b01, 16'hBEEF);
        push_cmd(4'h3, 6'h3F, 2'b11, 16'h0000);
        check_eq("s3_ready_at_3", bus.cmd_ready, 1'b1);
        push_cmd(4'h7, 6'h00, 2'b01, 16'h8001);
        check_eq("s3_ready_full", bus.cmd_ready, 1'b0);
        check_eq("s3_count_full", bus.fifo_count, 3'd4);
        push_cmd(4'hF, 6'h00, 2'b00, 16'hFFFF);
        check_eq("s3_count_after_5th", bus.fifo_count, 3'd4);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("s3_stall_valid", bus.instr_valid, 1'b1);
            check_eq("s3_stall_word", bus.instruction, exp_q[0]);
        end
        for (int i = 0; i < 4; i++) begin
            wait_valid("s3_drain_valid");
            check_eq("s3_drain_word", bus.instruction, exp_q[i]);
            bus.instr_ready = 1'b1;
            step();
            bus.instr_ready = 1'b0;
            check_eq("s3_drain_count", bus.fifo_count, 32'(3 - i));
            step();
            step();
            pulse_done();
        end
        step();
        step();
        check_eq("s3_no_fifth", bus.instr_valid, 1'b0);
        check_eq("s3_idle", bus.busy, 1'b0);

        // Timeout expiry, then the queued word issues
        push_cmd(4'h2, 6'h00, 2'b00, 16'h5555);
        push_cmd(4'hC, 6'h00, 2'b00, 16'h00F0);
        wait_valid("s4_valid_a");
        check_eq("s4_word_a", bus.instruction, fix(32'h0555_5002));
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        k = 0;
        while (bus.timeout !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        check_eq("s4_timeout_cycles", k, 255);
        step();
        check_eq("s4_timeout_one_cycle", bus.timeout, 1'b0);
        check_eq("s4_next_valid", bus.instr_valid, 1'b1);
        check_eq("s4_word_b", bus.instruction, fix(32'h000F_000C));
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 254; i++) begin
            step();
        end
        // cop_done lands on the expiry cycle: completion takes precedence
        pulse_done();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.timeout === 1'b1) pulses++;
            step();
        end
        check_eq("s4_done_wins_pulses", pulses, 0);
        check_eq("s4_done_wins_idle", bus.busy, 1'b0);

        // Asynchronous reset while waiting with two words queued
        push_cmd(4'h1, 6'h01, 2'b00, 16'h1111);
        push_cmd(4'hA, 6'h2A, 2'b01, 16'hBEEF);
        push_cmd(4'h3, 6'h3F, 2'b11, 16'h0000);
        wait_valid("s5_valid");
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check_eq("s5_queued", bus.fifo_count, 3'd2);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("s5_rst_count", bus.fifo_count, 3'd0);
        check_eq("s5_rst_busy", bus.busy, 1'b0);
        check_eq("s5_rst_ready", bus.cmd_ready, 1'b1);
        check_eq("s5_rst_valid", bus.instr_valid, 1'b0);
        check_eq("s5_rst_word", bus.instruction, 32'h0);
        check_eq("s5_rst_timeout", bus.timeout, 1'b0);
        step();
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.instr_valid === 1'b1) seen_valid++;
        end
        check_eq("s5_no_reissue", seen_valid, 0);
        check_eq("s5_idle_busy", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
